// File: rtl/ir_pkg.sv
// Shared state encoding and NEC segment lengths, in base units, for the IR transmitter.
package ir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK
    } ir_state_e;

    localparam int unsigned LEAD_MARK_UNITS  = 16;
    localparam int unsigned LEAD_SPACE_UNITS = 8;
    localparam int unsigned RPT_SPACE_UNITS  = 4;
    localparam int unsigned BIT_MARK_UNITS   = 1;
    localparam int unsigned ZERO_SPACE_UNITS = 1;
    localparam int unsigned ONE_SPACE_UNITS  = 3;
    localparam int unsigned STOP_UNITS       = 1;
    localparam int unsigned NEC_BITS         = 32;

    function automatic logic is_mark(input ir_state_e s);
        return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Free-running carrier divider. sync_clear restarts the period so that every mark
// begins on the high phase of the carrier.
module ir_carrier_gen #(
    parameter int unsigned CARRIER_DIV  = 1316,
    parameter int unsigned CARRIER_HIGH = 439
) (
    input  logic clk_50,
    input  logic rst_n,
    input  logic sync_clear,
    output logic carrier
);

    localparam int unsigned CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (sync_clear || (cnt_q == CW'(CARRIER_DIV - 1))) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign carrier = (32'(cnt_q) < CARRIER_HIGH);

endmodule

// File: rtl/ir_nec_transmitter.sv
// NEC frame serialiser: leader, 32 pulse-distance bits sent LSB first, stop mark.
// Requests are only taken in IDLE; start has priority over repeat_code.
module ir_nec_transmitter
    import ir_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES  = 28125,
    parameter int unsigned CARRIER_DIV  = 1316,
    parameter int unsigned CARRIER_HIGH = 439,
    parameter int unsigned MODULATE     = 1
) (
    input  logic        clk_50,
    input  logic        rst_n,
    input  logic        start,
    input  logic        repeat_code,
    input  logic [31:0] data,
    output logic        busy,
    output logic        done,
    output logic        ir_envelope,
    output logic        ir_tx
);

    localparam int unsigned UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);

    ir_state_e   state_q, state_d;
    logic [UW-1:0] unit_cnt_q, unit_cnt_d;
    logic [4:0]  seg_cnt_q, seg_cnt_d;
    logic [4:0]  bit_idx_q, bit_idx_d;
    logic [31:0] data_q, data_d;
    logic        rpt_q, rpt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        env_q, env_d;
    logic [4:0]  seg_len;
    logic        seg_end;
    logic        carrier;

    // Length of the current segment in base units.
    always_comb begin
        seg_len = 5'd1;
        case (state_q)
            LEAD_MARK:  seg_len = 5'(LEAD_MARK_UNITS);
            LEAD_SPACE: seg_len = rpt_q ? 5'(RPT_SPACE_UNITS) : 5'(LEAD_SPACE_UNITS);
            BIT_MARK:   seg_len = 5'(BIT_MARK_UNITS);
            BIT_SPACE:  seg_len = data_q[bit_idx_q] ? 5'(ONE_SPACE_UNITS) : 5'(ZERO_SPACE_UNITS);
            STOP_MARK:  seg_len = 5'(STOP_UNITS);
            default:    seg_len = 5'd1;
        endcase
    end

    assign seg_end = (unit_cnt_q == UNIT_LAST) && (seg_cnt_q == seg_len - 5'd1);

    always_comb begin
        state_d    = state_q;
        unit_cnt_d = unit_cnt_q;
        seg_cnt_d  = seg_cnt_q;
        bit_idx_d  = bit_idx_q;
        data_d     = data_q;
        rpt_d      = rpt_q;
        if (state_q == IDLE) begin
            if (start || repeat_code) begin
                state_d    = LEAD_MARK;
                rpt_d      = !start;
                data_d     = start ? data : data_q;
                unit_cnt_d = '0;
                seg_cnt_d  = '0;
                bit_idx_d  = '0;
            end
        end else if (unit_cnt_q != UNIT_LAST) begin
            unit_cnt_d = unit_cnt_q + 1'b1;
        end else begin
            unit_cnt_d = '0;
            if (!seg_end) begin
                seg_cnt_d = seg_cnt_q + 5'd1;
            end else begin
                seg_cnt_d = '0;
                case (state_q)
                    LEAD_MARK:  state_d = LEAD_SPACE;
                    LEAD_SPACE: state_d = rpt_q ? STOP_MARK : BIT_MARK;
                    BIT_MARK:   state_d = BIT_SPACE;
                    BIT_SPACE: begin
                        // Saturate at the last bit instead of wrapping back to bit 0.
                        if (bit_idx_q == 5'(NEC_BITS - 1)) begin
                            state_d = STOP_MARK;
                        end else begin
                            bit_idx_d = bit_idx_q + 5'd1;
                            state_d   = BIT_MARK;
                        end
                    end
                    STOP_MARK: begin
                        state_d   = IDLE;
                        bit_idx_d = '0;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
        busy_d = (state_d != IDLE);
        env_d  = is_mark(state_d);
        done_d = (state_q == STOP_MARK) && (state_d == IDLE);
    end

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            unit_cnt_q <= '0;
            seg_cnt_q  <= '0;
            bit_idx_q  <= '0;
            data_q     <= '0;
            rpt_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            env_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            unit_cnt_q <= unit_cnt_d;
            seg_cnt_q  <= seg_cnt_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            rpt_q      <= rpt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            env_q      <= env_d;
        end
    end

    // Marks always follow a space or IDLE, so a rising envelope marks a mark's first cycle.
    ir_carrier_gen #(
        .CARRIER_DIV  (CARRIER_DIV),
        .CARRIER_HIGH (CARRIER_HIGH)
    ) u_carrier (
        .clk_50     (clk_50),
        .rst_n      (rst_n),
        .sync_clear (env_d & ~env_q),
        .carrier    (carrier)
    );

    assign busy        = busy_q;
    assign done        = done_q;
    assign ir_envelope = env_q;
    assign ir_tx       = (MODULATE != 0) ? (env_q & carrier) : env_q;

endmodule

// File: tb/tb_ir_nec_transmitter.sv
// Directed bench for ir_nec_transmitter with shortened unit and carrier timing.
module tb_ir_nec_transmitter;

    localparam int UNIT     = 10;
    localparam int DIV      = 4;
    localparam int HIGH     = 2;
    localparam int MAX_WAIT = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        repeat_code = 1'b0;
    logic [31:0] data = '0;
    logic        busy, done, env, tx;
    logic        busy0, done0, env0, tx0;

    int cnt_checks = 0;
    int cnt_fail   = 0;

    typedef struct {
        logic        st;
        logic        rp;
        logic [31:0] d;
        int          exp_busy;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    ir_nec_transmitter #(
        .UNIT_CYCLES(UNIT), .CARRIER_DIV(DIV), .CARRIER_HIGH(HIGH), .MODULATE(1)
    ) dut (
        .clk_50(clk), .rst_n(rst_n), .start(start), .repeat_code(repeat_code),
        .data(data), .busy(busy), .done(done), .ir_envelope(env), .ir_tx(tx)
    );

    ir_nec_transmitter #(
        .UNIT_CYCLES(UNIT), .CARRIER_DIV(DIV), .CARRIER_HIGH(HIGH), .MODULATE(0)
    ) dut_nomod (
        .clk_50(clk), .rst_n(rst_n), .start(start), .repeat_code(repeat_code),
        .data(data), .busy(busy0), .done(done0), .ir_envelope(env0), .ir_tx(tx0)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cnt_checks++;
        if (act !== exp) begin
            cnt_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic st, input logic rp, input logic [31:0] d);
        @(negedge clk);
        start       = st;
        repeat_code = rp;
        data        = d;
    endtask

    // Follows one frame from the cycle after acceptance to its done pulse.
    task automatic watch(input logic rp, input logic [31:0] d, input int exp_busy,
                         input logic chain, input logic [31:0] chain_d);
        int   runs[$];
        int   exp_runs[$];
        int   busy_n = 0, done_c = 0, cur_len = 0;
        int   tx_bad = 0, tx0_bad = 0, run_bad = 0, n;
        logic cur_lvl = 1'b1;
        logic exp_tx;
        logic [31:0] dec = '0;

        exp_runs.push_back(16 * UNIT);
        exp_runs.push_back((rp ? 4 : 8) * UNIT);
        if (!rp) begin
            for (int b = 0; b < 32; b++) begin
                exp_runs.push_back(UNIT);
                exp_runs.push_back((d[b] ? 3 : 1) * UNIT);
            end
        end
        exp_runs.push_back(UNIT);

        for (int c = 1; c <= MAX_WAIT && done_c == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin start = 1'b0; repeat_code = 1'b0; end
            if (c == 2) data = ~d;
            if (c == 50) start = 1'b1;
            if (c == 51) start = 1'b0;
            if (c == 60) repeat_code = 1'b1;
            if (c == 61) repeat_code = 1'b0;
            if (busy) begin
                busy_n++;
                if (env == cur_lvl) begin
                    cur_len++;
                end else begin
                    runs.push_back(cur_len);
                    cur_lvl = env;
                    cur_len = 1;
                end
                exp_tx = env && (((cur_len - 1) % DIV) < HIGH);
                if (tx !== exp_tx) tx_bad++;
            end
            if (tx0 !== env0) tx0_bad++;
            if (done) begin
                done_c = c;
                check("done_busy_low", {31'b0, busy}, 32'd0);
                check("done_env_low", {31'b0, env}, 32'd0);
                if (chain) begin
                    start = 1'b1;
                    data  = chain_d;
                end
            end
        end
        runs.push_back(cur_len);

        if (done_c == 0) check("done_timeout", 32'd0, 32'd1);
        check("busy_cycles", busy_n, exp_busy);
        check("done_cycle", done_c, exp_busy + 1);
        check("run_count", runs.size(), exp_runs.size());
        n = (runs.size() < exp_runs.size()) ? runs.size() : exp_runs.size();
        for (int i = 0; i < n; i++) if (runs[i] != exp_runs[i]) run_bad++;
        check("run_lengths", run_bad, 32'd0);
        if (!rp && runs.size() == 67) begin
            for (int b = 0; b < 32; b++) dec[b] = (runs[3 + 2 * b] > 2 * UNIT);
            check("decoded_data", dec, d);
        end
        check("tx_pattern", tx_bad, 32'd0);
        check("tx_nomod", tx0_bad, 32'd0);
    endtask

    initial begin
        vecs[0] = '{st: 1'b1, rp: 1'b0, d: 32'h0000_0000, exp_busy: 890};
        vecs[1] = '{st: 1'b1, rp: 1'b0, d: 32'h00FF_00FF, exp_busy: 1210};
        vecs[2] = '{st: 1'b0, rp: 1'b1, d: 32'hDEAD_BEEF, exp_busy: 210};
        vecs[3] = '{st: 1'b1, rp: 1'b1, d: 32'h0000_0000, exp_busy: 890};
        vecs[4] = '{st: 1'b1, rp: 1'b0, d: 32'hFFFF_FFFF, exp_busy: 1530};
        vecs[5] = '{st: 1'b1, rp: 1'b0, d: 32'h8000_0000, exp_busy: 910};
        vecs[6] = '{st: 1'b1, rp: 1'b0, d: 32'hA5A5_A5A5, exp_busy: 1210};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_env", {31'b0, env}, 32'd0);
        check("reset_tx", {31'b0, tx}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].st, vecs[i].rp, vecs[i].d);
            watch(vecs[i].rp & ~vecs[i].st, vecs[i].d, vecs[i].exp_busy, 1'b0, 32'd0);
            @(negedge clk);
            check("not_queued", {31'b0, busy}, 32'd0);
        end

        // Back-to-back: next start accepted in the done cycle.
        issue(1'b1, 1'b0, 32'h1234_5678);
        watch(1'b0, 32'h1234_5678, 1150, 1'b1, 32'h0000_FFFF);
        watch(1'b0, 32'h0000_FFFF, 1210, 1'b0, 32'd0);

        // Reset mid-frame, then a clean frame.
        issue(1'b1, 1'b0, 32'hFFFF_FFFF);
        for (int c = 1; c <= 500; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_env", {31'b0, env}, 32'd0);
        check("midrst_tx", {31'b0, tx}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_idle", {30'b0, busy, done}, 32'd0);
        issue(1'b1, 1'b0, 32'h0000_0001);
        watch(1'b0, 32'h0000_0001, 910, 1'b0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", cnt_checks, cnt_fail);
        $finish;
    end

endmodule

// File: doc/ir_nec_transmitter.md
Name: ir_nec_transmitter

Overview:
- NEC-format IR transmitter; the send-side counterpart of the board's IR receive path.
- Takes a 32-bit code word plus start/repeat requests and serialises them into an NEC frame: leader, 32 pulse-distance bits, stop mark.
- Drives a 38 kHz-modulated output for an IR LED on a GPIO pin, plus an unmodulated envelope for loop-back into IR_RECEIVE.
- Bit 0 of the code word goes on air first, so the receiver's oDATA reproduces the word unchanged.

Parameters:
- UNIT_CYCLES, 28125, clk_50 cycles per NEC base unit (562.5 us at 50 MHz).
- CARRIER_DIV, 1316, clk_50 cycles per carrier period (about 38 kHz).
- CARRIER_HIGH, 439, carrier high cycles per period (about 1/3 duty).
- MODULATE, 1, 1 = ir_tx carries the carrier; 0 = ir_tx equals ir_envelope.

Ports:
- clk_50  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request to send a full frame with data.
- repeat_code  in  1  one-cycle request to send an NEC repeat code.
- data  in  32  code word; sampled only when start is accepted.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at end of frame.
- ir_envelope  out  1  unmodulated mark indicator (1 = mark).
- ir_tx  out  1  LED drive (modulated envelope).

Behaviour:
- Clock and reset: one clock, clk_50. Reset is synchronous, active-low on rst_n.
- Reset values: busy=0, done=0, ir_envelope=0, ir_tx=0; state IDLE; all counters 0.
- Reset mid-frame: all outputs return to 0 at the next edge, the latched word is discarded, and no done pulse is produced.
- Request acceptance:
  - A request is accepted only in IDLE.
  - start and repeat_code asserted in the same cycle: start wins.
  - Requests arriving while busy=1 are ignored, not queued.
- Latency:
  - On acceptance in cycle t0, data is latched.
  - busy and ir_envelope are 1 from cycle t0+1.
- States and durations (in units):
  - LEAD_MARK: 16.
  - LEAD_SPACE: 8 for a full frame, 4 for a repeat code. A repeat code then goes straight to STOP_MARK.
  - BIT_MARK: 1.
  - BIT_SPACE: 1 if the current bit is 0, 3 if it is 1.
  - Bit sequence: BIT_MARK/BIT_SPACE alternate for bit index 0..31, then STOP_MARK (1).
  - After STOP_MARK: IDLE.
- Envelope: ir_envelope=1 in every *_MARK state, 0 in every *_SPACE state and in IDLE.
- Frame length: FRAME_UNITS = 16+8+sum over bits(2 or 4)+1. This gives 89 units for all-zeros data, 153 for all-ones, and 21 for a repeat code.
- busy is high for exactly FRAME_UNITS*UNIT_CYCLES cycles.
- done pulses in the first cycle after that, with busy=0 in the same cycle. A new request is accepted in that same done cycle.
- Counters:
  - Unit counter runs 0..UNIT_CYCLES-1.
  - Segment counter counts units within a state.
  - Bit index is 5 bits; it must not wrap past 31 into bit 0.
- Carrier:
  - Counter runs 0..CARRIER_DIV-1 and is forced to 0 on the first cycle of every mark, so each mark starts high.
  - ir_tx = ir_envelope & (carrier_cnt < CARRIER_HIGH) when MODULATE=1.
  - ir_tx is 0 whenever the envelope is 0.
- No automatic inter-frame gap; the caller paces frames (108 ms NEC period).

Decomposition:
- Package ir_pkg:
  - State enum: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK.
  - Constants: LEAD_MARK_UNITS=16, LEAD_SPACE_UNITS=8, RPT_SPACE_UNITS=4, BIT_MARK_UNITS=1, ZERO_SPACE_UNITS=1, ONE_SPACE_UNITS=3, STOP_UNITS=1, NEC_BITS=32.
- Sub-module ir_carrier_gen:
  - Parameters CARRIER_DIV and CARRIER_HIGH.
  - Inputs: clk_50, rst_n, sync_clear.
  - Output: carrier.
- FSM and bit serialiser stay in the top module.

Test Plan:
Sim parameters for all scenarios: UNIT_CYCLES=10, CARRIER_DIV=4, CARRIER_HIGH=2.
- start with data=0x0000_0000 at t0 -> envelope high for cycles t0+1..t0+160, then low for 80 cycles. Then 32 repetitions of 10 high / 10 low, then 10 high. done at t0+891; busy high for exactly 890 cycles.
- start with data=0x00FF_00FF -> envelope bit timing is 10 high / 30 low for bits 0-7 and 16-23, and 10 high / 10 low for the rest. busy high 1210 cycles; loop-back through IR_RECEIVE (real timing parameters) yields oDATA=0x00FF_00FF.
- repeat_code pulse -> 160 high, 40 low, 10 high; busy high 210 cycles, then done.
- start and repeat_code in the same cycle -> full frame. A start 50 cycles into the frame is ignored; data changes after acceptance have no effect.
- rst_n low for one cycle 500 cycles into a frame -> all outputs 0 next edge and no done. A start 2 cycles later begins a clean frame.
- MODULATE=1 -> ir_tx pattern 1,1,0,0 repeating within marks, starting with 1 at each mark's first cycle, and 0 during spaces. MODULATE=0 -> ir_tx==ir_envelope every cycle.
